// File: rtl/im_loader_pkg.sv
// Shared constants and types for the instruction-memory loader, the
// instruction memory and the CPU top.
package im_loader_pkg;

    localparam int IM_ADDR_W = 8;
    localparam int IM_DEPTH  = 1 << IM_ADDR_W;
    localparam int IM_DATA_W = 32;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE
    } state_e;

    // A count byte of zero stands for a full memory image.
    function automatic logic [8:0] word_count(input logic [7:0] n);
        return (n == 8'd0) ? 9'(IM_DEPTH) : {1'b0, n};
    endfunction

endpackage

// File: rtl/im_loader_byte_word_packer.sv
// byte_word_packer: assembles big-endian 32-bit words from a byte stream and
// keeps a running XOR of every byte loaded since the last clear.
module im_loader_byte_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o,
    output logic [7:0]  csum_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [1:0]  cnt_q;
    logic [7:0]  csum_q;

    assign word_d = {word_q[23:0], byte_i};

    // Shift in bytes MSB first, count them and fold them into the checksum.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            csum_q <= '0;
        end else if (load_i) begin
            word_q <= word_d;
            cnt_q  <= cnt_q + 2'd1;
            csum_q <= csum_q ^ byte_i;
        end
    end

    // The word is presented as it stands once the current byte is in, so the
    // loader can register it on the same edge the 4th byte arrives.
    assign word_o = load_i ? word_d : word_q;
    assign full_o = load_i && (cnt_q == 2'd3);
    assign csum_o = csum_q;

endmodule

// File: rtl/im_loader.sv
// Serial instruction loader: receives a framed byte stream and writes the
// assembled words into the instruction memory, holding the CPU in reset
// while a frame is in progress.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | hunting for the sync byte, other bytes are dropped
// COUNT  | next byte is the word count (0 = 256 words)
// DATA   | collecting the 4 payload bytes of the current word
// WRITE  | one-cycle memory write of the assembled word, input stalled
// CSUM   | next byte is the XOR checksum of the payload
// DONE   | end-of-frame pulse, CPU released
module im_loader
    import im_loader_pkg::*;
#(
    parameter int                ADDR_W    = IM_ADDR_W,
    parameter logic [7:0]        SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst1,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 im_wea,
    output logic [ADDR_W-1:0]    im_addr,
    output logic [IM_DATA_W-1:0] im_din,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 csum_err
);

    state_e                 state_q;
    logic                   ready_q;
    logic                   wea_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [IM_DATA_W-1:0]   din_q;
    logic                   hold_q;
    logic                   done_q;
    logic                   err_q;
    logic [8:0]             n_q;
    logic [8:0]             k_q;
    logic [8:0]             k_d;
    logic [ADDR_W-1:0]      k_addr;

    logic                   xfer;
    logic                   pk_load;
    logic                   pk_clear;
    logic [31:0]            pk_word;
    logic                   pk_full;
    logic [7:0]             pk_csum;

    assign xfer     = byte_valid && ready_q;
    assign pk_clear = (state_q == ST_COUNT) && xfer;
    assign pk_load  = (state_q == ST_DATA) && xfer;
    assign k_d      = k_q + 9'd1;
    assign k_addr   = ADDR_W'(k_q);

    im_loader_byte_word_packer u_packer (
        .clk_i   (clk),
        .rst_i   (rst1),
        .load_i  (pk_load),
        .clear_i (pk_clear),
        .byte_i  (byte_data),
        .word_o  (pk_word),
        .full_o  (pk_full),
        .csum_o  (pk_csum)
    );

    // Frame sequencer; every output is a register set one cycle ahead.
    always_ff @(posedge clk) begin
        if (rst1) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            wea_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            wea_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (xfer && (byte_data == SYNC_BYTE)) begin
                        state_q <= ST_COUNT;
                        hold_q  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (xfer) begin
                        n_q     <= word_count(byte_data);
                        k_q     <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pk_full) begin
                        ready_q <= 1'b0;
                        wea_q   <= 1'b1;
                        addr_q  <= BASE_ADDR + k_addr;
                        din_q   <= pk_word;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ready_q <= 1'b1;
                    k_q     <= k_d;
                    state_q <= (k_d == n_q) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (xfer) begin
                        err_q   <= (byte_data != pk_csum);
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    hold_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = ready_q;
    assign im_wea     = wea_q;
    assign im_addr    = addr_q;
    assign im_din     = din_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign csum_err   = err_q;

endmodule
